atomrvcore_dccm_arbiter: RTL and testbench
==========================================

# atomrvcore_dccm_arbiter

Shares the single data-memory (DCCM) port between the core load/store path and a host/debug port used to preload and inspect data memory. Issues at most one access per cycle, returns read data one cycle after the grant, and prevents host starvation with a bounded-wait counter. An exclusive host lock mode supports bulk loading while the core is held off. Sits between the decoder/register-file data path and the DCCM instance in the core top level.

## Interface
- DATAWIDTH, 32, data word width
- ADDR_WIDTH, 32, byte address width
- STARVE_LIMIT, 4, consecutive denied host cycles before host is forced to win (range 1..15)

- clk_i  in  1  core clock, all state on rising edge
- rst_i  in  1  asynchronous, active-high reset
- core_req_i / core_we_i  in  1/1  core access request / write (1) or read (0)
- core_addr_i  in  ADDR_WIDTH  core address
- core_wdata_i  in  DATAWIDTH  core store data
- core_gnt_o  out  1  core request accepted this cycle
- core_rvalid_o  out  1  core read data valid
- core_rdata_o  out  DATAWIDTH  core read data
- host_req_i, host_we_i, host_addr_i, host_wdata_i, host_gnt_o, host_rvalid_o, host_rdata_o: same as the core_ ports, host side
- host_lock_i  in  1  host requests exclusive ownership
- host_locked_o  out  1  lock is in effect
- mem_addr_o  out  ADDR_WIDTH  to DCCM address_i
- mem_dt_o  out  DATAWIDTH  to DCCM DT_i
- mem_dwr_en_o / mem_dr_en_o  out  1/1  to DCCM DWR_EN_i / DR_EN_i
- mem_dt_i  in  DATAWIDTH  from DCCM DT_o, valid the cycle after mem_dr_en_o

## Operation
- FSM states: NORMAL, LOCKED.
- NORMAL: the core wins simultaneous requests unless the starvation counter equals STARVE_LIMIT, in which case the host wins. A lone requester always wins.
- Starvation counter (4 bits):
  - increments when host_req_i=1 and the host is not granted;
  - clears on a host grant or when host_req_i=0;
  - saturates at STARVE_LIMIT.
- NORMAL->LOCKED when host_lock_i=1. The transition is taken in the same cycle; a read issued in the previous cycle still returns to its owner.
- LOCKED: only the host can be granted, and core_gnt_o=0. Exit to NORMAL on the first cycle host_lock_i=0. The counter is held at 0 in LOCKED.
- Grant is combinational from the current requests and state: gnt_o=1 in the same cycle as req_i. The memory outputs are driven combinationally from the winner. mem_dwr_en_o=winner&we and mem_dr_en_o=winner&~we. With no winner, both enables are 0 and address/data are 0.
- Read return:
  - rd_owner (none/core/host) is registered on a read grant.
  - The next cycle, the owner's rvalid_o=1 and its rdata_o=mem_dt_i.
  - The non-owner's rdata_o=0.
  - Writes produce no rvalid.
- Back-to-back reads are fully pipelined: one grant per cycle, one rvalid per cycle.

## Timing
- Reset values: FSM=NORMAL, counter=0, rd_owner=none. All gnt/rvalid/rdata/host_locked_o/mem_* outputs=0, given that req/lock inputs are 0.
- Latency: grant 0 cycles; read data 1 cycle after grant; write visible in DCCM at the grant-cycle clock edge.
- host_locked_o is registered: it goes 1 the cycle after host_lock_i rises, and 0 the cycle after it falls. Grant gating uses the combinational lock condition (host_lock_i), so the core is blocked from the first lock cycle.
- Simultaneous read-return and new grant are legal: rvalid for the previous access and gnt for the new one in the same cycle.
- Reset mid-read: a pending rvalid is dropped, and no rvalid appears after reset deasserts.
- The requester must hold req/we/addr/wdata stable until gnt; a dropped req is permitted and is never granted retroactively.

## Structure
- Shared package atomrvcore_pkg:
  - typedef enum logic {ARB_NORMAL, ARB_LOCKED} arb_state_e;
  - typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_HOST} rd_owner_e;
  - localparam STARVE_CNT_W=4.
- One sub-module: atomrvcore_starve_counter, a saturating counter with inc/clr/limit-hit. Everything else stays flat in the arbiter.

## Test plan
- Core-only read of addr 0x10 with DCCM word 0xDEADBEEF -> core_gnt_o=1 and mem_dr_en_o=1 in cycle 0; core_rvalid_o=1 with core_rdata_o=0xDEADBEEF in cycle 1; host outputs stay 0.
- Core and host both requesting continuously, STARVE_LIMIT=4 -> core granted 4 cycles, host granted on the 5th, pattern repeats.
- Host lock asserted while core requests; host writes 0x1,0x2,0x3 to 0x0/0x4/0x8 -> core_gnt_o=0 throughout; host_locked_o=1 from the 2nd cycle; DCCM holds the values; the core is granted the first cycle after lock drops.
- Alternating core read / host read every cycle -> each rvalid goes only to the issuing owner with the correct data; no cycle has both rvalids high.
- rst_i pulsed one cycle after a core read grant -> core_rvalid_o stays 0; all outputs and the counter read 0; normal operation resumes after deassertion.
- Write then read of the same address back-to-back from the host (0x20, 0xA5A5A5A5) -> the read returns 0xA5A5A5A5 one cycle after its grant.

Source files
------------

// File: rtl/atomrvcore_dccm_arbiter_pkg.sv
// ============================================================================
// Module   : atomrvcore_pkg
// Brief    : Shared types for the DCCM arbiter (FSM states, read-owner tags).
// Revision : 1.0
// ============================================================================
`default_nettype none

package atomrvcore_pkg;

    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2
    } rd_owner_e;

    localparam int STARVE_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/atomrvcore_dccm_arbiter_if.sv
// ============================================================================
// Module   : atomrvcore_dccm_arbiter_if
// Brief    : Core, host and DCCM-side signals of the DCCM arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface atomrvcore_dccm_arbiter_if #(
    parameter int DATAWIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                  core_req_i;
    logic                  core_we_i;
    logic [ADDR_WIDTH-1:0] core_addr_i;
    logic [DATAWIDTH-1:0]  core_wdata_i;
    logic                  core_gnt_o;
    logic                  core_rvalid_o;
    logic [DATAWIDTH-1:0]  core_rdata_o;

    logic                  host_req_i;
    logic                  host_we_i;
    logic [ADDR_WIDTH-1:0] host_addr_i;
    logic [DATAWIDTH-1:0]  host_wdata_i;
    logic                  host_gnt_o;
    logic                  host_rvalid_o;
    logic [DATAWIDTH-1:0]  host_rdata_o;
    logic                  host_lock_i;
    logic                  host_locked_o;

    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATAWIDTH-1:0]  mem_dt_o;
    logic                  mem_dwr_en_o;
    logic                  mem_dr_en_o;
    logic [DATAWIDTH-1:0]  mem_dt_i;

    modport slave (
        input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
        output core_gnt_o, core_rvalid_o, core_rdata_o,
        input  host_req_i, host_we_i, host_addr_i, host_wdata_i, host_lock_i,
        output host_gnt_o, host_rvalid_o, host_rdata_o, host_locked_o,
        output mem_addr_o, mem_dt_o, mem_dwr_en_o, mem_dr_en_o,
        input  mem_dt_i
    );

    modport master (
        output core_req_i, core_we_i, core_addr_i, core_wdata_i,
        input  core_gnt_o, core_rvalid_o, core_rdata_o,
        output host_req_i, host_we_i, host_addr_i, host_wdata_i, host_lock_i,
        input  host_gnt_o, host_rvalid_o, host_rdata_o, host_locked_o,
        input  mem_addr_o, mem_dt_o, mem_dwr_en_o, mem_dr_en_o,
        output mem_dt_i
    );
endinterface

`default_nettype wire

// File: rtl/atomrvcore_starve_counter.sv
// ============================================================================
// Module   : atomrvcore_starve_counter
// Brief    : Saturating count of consecutive denied host cycles.
// Revision : 1.0
// ============================================================================
`default_nettype none

module atomrvcore_starve_counter
    import atomrvcore_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  wire  clk_i,
    input  wire  rst_i,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_limit_hit
);
    localparam logic [STARVE_CNT_W-1:0] C_LIMIT = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] r_cnt;

    // Clear has priority so a grant and a denial never race.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != C_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_limit_hit = (r_cnt == C_LIMIT);

endmodule

`default_nettype wire

// File: rtl/atomrvcore_dccm_arbiter.sv
// ============================================================================
// Module   : atomrvcore_dccm_arbiter
// Brief    : Core/host arbiter for the single DCCM port with anti-starvation
//            and an exclusive host lock mode.
// Revision : 1.0
// ============================================================================
`default_nettype none

module atomrvcore_dccm_arbiter
    import atomrvcore_pkg::*;
#(
    parameter int DATAWIDTH    = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire                        clk_i,
    input  wire                        rst_i,
    atomrvcore_dccm_arbiter_if.slave   bus
);
    arb_state_e            r_state;
    arb_state_e            w_state_nxt;
    rd_owner_e             r_rd_owner;
    rd_owner_e             w_rd_owner_nxt;
    logic                  w_lock;
    logic                  w_core_win;
    logic                  w_host_win;
    logic                  w_limit_hit;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    logic [DATAWIDTH-1:0]  w_mem_dt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= ARB_NORMAL;
            r_rd_owner <= OWN_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    // Lock takes effect in the cycle it is requested; the registered state
    // only feeds the host_locked status output.
    always_comb begin
        w_state_nxt = r_state;
        w_core_win  = 1'b0;
        w_host_win  = 1'b0;
        case (r_state)
            ARB_NORMAL: if (bus.host_lock_i)  w_state_nxt = ARB_LOCKED;
            ARB_LOCKED: if (!bus.host_lock_i) w_state_nxt = ARB_NORMAL;
            default:    w_state_nxt = ARB_NORMAL;
        endcase
        w_lock = (w_state_nxt == ARB_LOCKED);
        if (w_lock) begin
            w_host_win = bus.host_req_i;
        end else if (bus.core_req_i && bus.host_req_i) begin
            w_host_win = w_limit_hit;
            w_core_win = !w_limit_hit;
        end else begin
            w_core_win = bus.core_req_i;
            w_host_win = bus.host_req_i;
        end
    end

    atomrvcore_starve_counter #(
        .LIMIT       (STARVE_LIMIT)
    ) u_starve (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_inc       (bus.host_req_i && !w_host_win),
        .i_clr       (!bus.host_req_i || w_host_win || w_lock),
        .o_limit_hit (w_limit_hit)
    );

    always_comb begin
        w_mem_addr = '0;
        w_mem_dt   = '0;
        if (w_host_win) begin
            w_mem_addr = bus.host_addr_i;
            w_mem_dt   = bus.host_wdata_i;
        end else if (w_core_win) begin
            w_mem_addr = bus.core_addr_i;
            w_mem_dt   = bus.core_wdata_i;
        end
    end

    always_comb begin
        w_rd_owner_nxt = OWN_NONE;
        if (w_host_win && !bus.host_we_i) begin
            w_rd_owner_nxt = OWN_HOST;
        end else if (w_core_win && !bus.core_we_i) begin
            w_rd_owner_nxt = OWN_CORE;
        end
    end

    assign bus.core_gnt_o    = w_core_win;
    assign bus.host_gnt_o    = w_host_win;
    assign bus.host_locked_o = (r_state == ARB_LOCKED);
    assign bus.mem_addr_o    = w_mem_addr;
    assign bus.mem_dt_o      = w_mem_dt;
    assign bus.mem_dwr_en_o  = (w_core_win && bus.core_we_i) || (w_host_win && bus.host_we_i);
    assign bus.mem_dr_en_o   = (w_core_win && !bus.core_we_i) || (w_host_win && !bus.host_we_i);

    assign bus.core_rvalid_o = (r_rd_owner == OWN_CORE);
    assign bus.host_rvalid_o = (r_rd_owner == OWN_HOST);
    assign bus.core_rdata_o  = (r_rd_owner == OWN_CORE) ? bus.mem_dt_i : '0;
    assign bus.host_rdata_o  = (r_rd_owner == OWN_HOST) ? bus.mem_dt_i : '0;

endmodule

`default_nettype wire

// File: tb/tb_atomrvcore_dccm_arbiter.sv
// ============================================================================
// Module   : tb_atomrvcore_dccm_arbiter
// Brief    : Self-checking bench with a behavioural DCCM and read scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_atomrvcore_dccm_arbiter;
    localparam int C_DW    = 32;
    localparam int C_AW    = 32;
    localparam int C_LIMIT = 4;

    typedef struct {
        bit        host;
        bit [31:0] data;
    } rd_exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    atomrvcore_dccm_arbiter_if #(.DATAWIDTH(C_DW), .ADDR_WIDTH(C_AW)) bus ();

    atomrvcore_dccm_arbiter #(
        .DATAWIDTH    (C_DW),
        .ADDR_WIDTH   (C_AW),
        .STARVE_LIMIT (C_LIMIT)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    // Behavioural DCCM: write at the clock edge, registered read data.
    bit   [31:0] r_dccm [256];
    logic [31:0] r_dccm_q = '0;
    always @(posedge clk_i) begin
        if (bus.mem_dwr_en_o) r_dccm[bus.mem_addr_o[9:2]] <= bus.mem_dt_o;
        if (bus.mem_dr_en_o)  r_dccm_q <= r_dccm[bus.mem_addr_o[9:2]];
    end
    assign bus.mem_dt_i = r_dccm_q;

    int        n_chk  = 0;
    int        n_fail = 0;
    int        m_cnt  = 0;
    bit        m_locked = 1'b0;
    bit [31:0] m_sh [256];
    rd_exp_t   m_q[$];
    bit        obs_hgnt;
    bit        obs_cgnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit creq, input bit cwe, input bit [31:0] caddr, input bit [31:0] cwd,
                         input bit hreq, input bit hwe, input bit [31:0] haddr, input bit [31:0] hwd,
                         input bit lock);
        bus.core_req_i = creq; bus.core_we_i = cwe; bus.core_addr_i = caddr; bus.core_wdata_i = cwd;
        bus.host_req_i = hreq; bus.host_we_i = hwe; bus.host_addr_i = haddr; bus.host_wdata_i = hwd;
        bus.host_lock_i = lock;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // One clock: check outputs mid-cycle against the model, then advance the model.
    task automatic step();
        bit        cg, hg, lk, cwe, hwe;
        bit [31:0] ea, ed, caddr, haddr;
        rd_exp_t   e;
        @(negedge clk_i);
        lk = bus.host_lock_i; cwe = bus.core_we_i; hwe = bus.host_we_i;
        caddr = bus.core_addr_i; haddr = bus.host_addr_i;
        cg = 1'b0; hg = 1'b0;
        if (lk) hg = bus.host_req_i;
        else if (bus.core_req_i && bus.host_req_i) begin
            hg = (m_cnt == C_LIMIT);
            cg = !hg;
        end else begin
            cg = bus.core_req_i;
            hg = bus.host_req_i;
        end
        ea = hg ? haddr : (cg ? caddr : 32'h0);
        ed = hg ? bus.host_wdata_i : (cg ? bus.core_wdata_i : 32'h0);
        obs_hgnt = bus.host_gnt_o;
        obs_cgnt = bus.core_gnt_o;
        chk("core_gnt", bus.core_gnt_o, cg);
        chk("host_gnt", bus.host_gnt_o, hg);
        chk("mem_dr_en", bus.mem_dr_en_o, (cg && !cwe) || (hg && !hwe));
        chk("mem_dwr_en", bus.mem_dwr_en_o, (cg && cwe) || (hg && hwe));
        chk("mem_addr", bus.mem_addr_o, ea);
        chk("mem_dt", bus.mem_dt_o, ed);
        chk("host_locked", bus.host_locked_o, m_locked);
        if (m_q.size() > 0) begin
            e = m_q.pop_front();
            chk("core_rvalid", bus.core_rvalid_o, !e.host);
            chk("host_rvalid", bus.host_rvalid_o, e.host);
            chk("core_rdata", bus.core_rdata_o, e.host ? 32'h0 : e.data);
            chk("host_rdata", bus.host_rdata_o, e.host ? e.data : 32'h0);
        end else begin
            chk("core_rvalid_idle", bus.core_rvalid_o, 1'b0);
            chk("host_rvalid_idle", bus.host_rvalid_o, 1'b0);
            chk("core_rdata_idle", bus.core_rdata_o, 32'h0);
            chk("host_rdata_idle", bus.host_rdata_o, 32'h0);
        end
        @(posedge clk_i);
        m_locked = lk;
        if (lk || !bus.host_req_i || hg) m_cnt = 0;
        else if (m_cnt < C_LIMIT) m_cnt++;
        if (hg) begin
            if (hwe) m_sh[haddr[9:2]] = bus.host_wdata_i;
            else begin e.host = 1'b1; e.data = m_sh[haddr[9:2]]; m_q.push_back(e); end
        end else if (cg) begin
            if (cwe) m_sh[caddr[9:2]] = bus.core_wdata_i;
            else begin e.host = 1'b0; e.data = m_sh[caddr[9:2]]; m_q.push_back(e); end
        end
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk_i);
        chk({tag, "_core_gnt"}, bus.core_gnt_o, 1'b0);
        chk({tag, "_host_gnt"}, bus.host_gnt_o, 1'b0);
        chk({tag, "_core_rvalid"}, bus.core_rvalid_o, 1'b0);
        chk({tag, "_host_rvalid"}, bus.host_rvalid_o, 1'b0);
        chk({tag, "_rdata"}, {bus.core_rdata_o, bus.host_rdata_o}, 64'h0);
        chk({tag, "_locked"}, bus.host_locked_o, 1'b0);
        chk({tag, "_mem_en"}, {bus.mem_dwr_en_o, bus.mem_dr_en_o}, 2'b00);
        chk({tag, "_mem_bus"}, {bus.mem_addr_o, bus.mem_dt_o}, 64'h0);
    endtask

    task automatic reset_model();
        m_q.delete();
        m_cnt = 0;
        m_locked = 1'b0;
    endtask

    initial begin
        bit [9:0] pat;
        idle();
        reset_model();
        check_reset_outputs("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Preload 0x10 from the host, then a lone core read of it.
        drive(0, 0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF, 0); step();
        idle(); step();
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0); step();
        idle(); step();

        // Continuous contention: host should win every fifth cycle.
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 32'h10, 0, 1, 0, 32'h14, 0, 0); step();
            pat[i] = obs_hgnt;
        end
        chk("starve_pattern", pat, 10'b10000_10000);
        idle(); step();

        // Host lock with core blocked, three host writes, then release.
        drive(1, 0, 32'h40, 0, 1, 1, 32'h0, 32'h1, 1); step();
        drive(1, 0, 32'h40, 0, 1, 1, 32'h4, 32'h2, 1); step();
        drive(1, 0, 32'h40, 0, 1, 1, 32'h8, 32'h3, 1); step();
        drive(1, 0, 32'h40, 0, 0, 0, 0, 0, 0); step();
        chk("core_after_unlock", obs_cgnt, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 0, 32'(i * 4), 0, 0); step();
        end
        idle(); step();

        // Alternating lone core and host reads.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(1, 0, 32'(i * 4), 0, 0, 0, 0, 0, 0);
            else            drive(0, 0, 0, 0, 1, 0, 32'(i * 4), 0, 0);
            step();
        end
        idle(); step();

        // Reset pulse right after a core read grant drops the pending rvalid.
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0); step();
        idle();
        rst_i = 1'b1;
        reset_model();
        check_reset_outputs("midread");
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        step();

        // Host write then immediate read of the same word.
        drive(0, 0, 0, 0, 1, 1, 32'h20, 32'hA5A5A5A5, 0); step();
        drive(0, 0, 0, 0, 1, 0, 32'h20, 0, 0); step();
        idle(); step();

        // Random mixed traffic.
        for (int i = 0; i < 80; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 1), 32'($urandom_range(0, 15) * 4), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 1), 32'($urandom_range(0, 15) * 4), $urandom,
                  $urandom_range(0, 7) == 0);
            step();
        end
        idle(); step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
